// File: rtl/z80_bus_mem.sv
// z80_bus_mem: tv80s bus memory/IO responder with wait insertion, backdoor preload and optional write trace (Z80_BUS_MEM_TRACE_EN)
module z80_bus_mem #(
  parameter int         ADDR_W      = 16,
  parameter logic [7:0] IO_PAGE     = 8'h10,
  parameter int         MEM_WAIT    = 0,
  parameter int         IO_WAIT     = 0,
  parameter logic [7:0] INT_VECTOR  = 8'hFF,
  parameter int         TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       a,
  input  logic [7:0]        cpu_do,
  output logic [7:0]        cpu_di,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              rfsh_n,
  output logic              wait_n,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_data,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [24:0]       trc_data,
  output logic              trc_ovf
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  logic [7:0] mem [2**ADDR_W];
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx, n_wait;
  logic [7:0] rd_q;
  logic done, idle_q, int_ack, idle, act, new_cyc, commit, clash, unused_rd;
  logic [15:0] sel_addr;
  logic [ADDR_W-1:0] idx;
  assign unused_rd = rd_n;
  assign int_ack = !m1_n && !iorq_n;
  assign idle = mreq_n && iorq_n;
  assign act = (!mreq_n && rfsh_n) || !iorq_n;
  assign sel_addr = iorq_n ? a : {IO_PAGE, a[7:0]};
  assign idx = sel_addr[ADDR_W-1:0];
  assign n_wait = iorq_n ? 4'(MEM_WAIT) : 4'(IO_WAIT);
  assign wait_n = state != WAIT;
  assign cpu_di = int_ack ? INT_VECTOR : rd_q;
  assign commit = !wr_n && !idle && rfsh_n && !int_ack && wait_n && !done;
  assign clash = bd_we && bd_addr == idx;
  // A strobe seen low after an idle negedge starts a new cycle even if HOLD never saw it high
  assign new_cyc = act && (state == IDLE || (state == HOLD && idle_q));
  // Wait sequencing: load the per-cycle count, hold wait_n low until it runs out
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (new_cyc) begin
      state_nx = n_wait == 4'd0 ? HOLD : WAIT;
      cnt_nx = n_wait - 4'd1;
    end else if (state == WAIT) begin
      state_nx = cnt == 4'd0 ? HOLD : WAIT;
      cnt_nx = cnt - 4'd1;
    end else if (state == HOLD && idle) state_nx = IDLE;
  end
  // Wait FSM register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // Read data, per-cycle write-done flag and idle sample, all on the array edge
  always_ff @(negedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_q <= 8'h00;
      done <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      rd_q <= mem[idx];
      done <= idle ? 1'b0 : done | commit;
      idle_q <= idle;
    end
  // Array writes; the backdoor wins over a CPU write to the same byte
  always_ff @(negedge clk) begin
    if (reset_n && commit && !clash) mem[idx] <= cpu_do;
    if (bd_we) mem[bd_addr] <= bd_data;
  end
`ifdef Z80_BUS_MEM_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;
  logic [24:0] fq [TRACE_DEPTH];
  logic [24:0] push_d;
  logic push_q, push, pop, full;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt_t;
  assign full = cnt_t == CW'(TRACE_DEPTH);
  assign pop = trc_valid && trc_ready;
  assign push = push_q && (!full || pop);
  assign trc_valid = cnt_t != '0;
  assign trc_data = trc_valid ? fq[rp] : '0;
  // Capture the committed write at the array edge so the FIFO can run on posedge
  always_ff @(negedge clk or negedge reset_n)
    if (!reset_n) begin
      push_q <= 1'b0;
      push_d <= '0;
    end else begin
      push_q <= commit && !clash;
      push_d <= {!iorq_n, sel_addr, cpu_do};
    end
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt_t <= '0;
      trc_ovf <= 1'b0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt_t <= cnt_t + CW'(push) - CW'(pop);
      if (push_q && full && !pop) trc_ovf <= 1'b1;
    end
  // Entry storage is only observed through the occupancy count, so it is not reset
  always_ff @(posedge clk)
    if (push) fq[wp] <= push_d;
`else
  logic unused_trc;
  assign unused_trc = trc_ready;
  assign trc_valid = 1'b0;
  assign trc_data = '0;
  assign trc_ovf = 1'b0;
`endif
endmodule
